// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the barrel RISC-V core.
package riscv_pkg;
    localparam int NUM_THREADS = 16;
    localparam int ADDR_WIDTH = 10;
    localparam int PC_WIDTH = ADDR_WIDTH + 2;
    localparam int TID_WIDTH = $clog2(NUM_THREADS);
    localparam logic [PC_WIDTH-1:0] STARTUP_ADDR = 12'h000;
    typedef logic [TID_WIDTH-1:0] tid_t;
    typedef logic [PC_WIDTH-1:0] pc_t;
    typedef struct packed {
        logic valid;
        tid_t tid;
        pc_t  pc;
    } fetch_bundle_t;
endpackage

// File: rtl/thread_slot_counter.sv
// thread_slot_counter: modulo-N slot counter with enable and sync active-low reset.
module thread_slot_counter #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (!reset_n) count <= '0;
        else if (en) count <= (count == W'(N - 1)) ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/barrel_fetch_unit.sv
// barrel_fetch_unit: round-robin thread fetch with per-thread PCs, aligned to 1-cycle BRAM read.
module barrel_fetch_unit
    import riscv_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   run_en,
    input  logic [NUM_THREADS-1:0] thread_en,
    input  logic                   redirect_valid,
    input  tid_t                   redirect_tid,
    input  pc_t                    redirect_pc,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic                   imem_en,
    output logic                   fetch_valid,
    output tid_t                   fetch_tid,
    output pc_t                    fetch_pc
);
    localparam pc_t START_PC = STARTUP_ADDR & ~pc_t'(3);
    pc_t pc [NUM_THREADS];
    tid_t tid_q;
    pc_t cur_pc, new_pc;
    logic issue;
    fetch_bundle_t s1, s2;
    thread_slot_counter #(.N(NUM_THREADS)) u_slot (
        .clk(clk),
        .reset_n(reset_n),
        .en(run_en),
        .count(tid_q)
    );
    assign cur_pc = pc[tid_q];
    assign new_pc = redirect_pc & ~pc_t'(3);
    // a redirect to the current slot turns it into a bubble so the stale PC is never fetched
    assign issue = run_en & thread_en[tid_q] & ~(redirect_valid & (redirect_tid == tid_q));
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int t = 0; t < NUM_THREADS; t++) pc[t] <= START_PC;
            imem_addr <= '0;
            imem_en <= 1'b0;
            s1 <= '0;
            s2 <= '0;
        end else begin
            imem_addr <= cur_pc[PC_WIDTH-1:2];
            imem_en <= issue;
            s1 <= '{valid: issue, tid: tid_q, pc: cur_pc};
            s2 <= s1;
            if (issue) pc[tid_q] <= cur_pc + pc_t'(4);
            if (redirect_valid) pc[redirect_tid] <= new_pc;
        end
    end
    assign fetch_valid = s2.valid;
    assign fetch_tid = s2.tid;
    assign fetch_pc = s2.pc;
endmodule

// File: tb/tb_barrel_fetch_unit.sv
// tb_barrel_fetch_unit: directed self-checking bench for barrel_fetch_unit.
module tb_barrel_fetch_unit;
    import riscv_pkg::*;
    logic clk = 1'b0;
    logic reset_n;
    logic run_en;
    logic [NUM_THREADS-1:0] thread_en;
    logic redirect_valid;
    tid_t redirect_tid;
    pc_t redirect_pc;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic imem_en;
    logic fetch_valid;
    tid_t fetch_tid;
    pc_t fetch_pc;
    int checks = 0;
    int errors = 0;

    barrel_fetch_unit dut (
        .clk(clk),
        .reset_n(reset_n),
        .run_en(run_en),
        .thread_en(thread_en),
        .redirect_valid(redirect_valid),
        .redirect_tid(redirect_tid),
        .redirect_pc(redirect_pc),
        .imem_addr(imem_addr),
        .imem_en(imem_en),
        .fetch_valid(fetch_valid),
        .fetch_tid(fetch_tid),
        .fetch_pc(fetch_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        run_en = 1'b0;
        thread_en = '1;
        redirect_valid = 1'b0;
        redirect_tid = '0;
        redirect_pc = '0;
        tick();
        reset_n = 1'b1;
        run_en = 1'b1;
    endtask

    task automatic redirect(input tid_t t, input pc_t p);
        redirect_valid = 1'b1;
        redirect_tid = t;
        redirect_pc = p;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_imem_en", 32'(imem_en), 0);
        chk("rst_imem_addr", 32'(imem_addr), 0);
        chk("rst_fvalid", 32'(fetch_valid), 0);
        chk("rst_ftid", 32'(fetch_tid), 0);
        chk("rst_fpc", 32'(fetch_pc), 0);

        // 1: free run, slot j processed at edge j+1, fetched after edge j+2
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk("t1_addr", 32'(imem_addr), 32'((k - 1) / 16));
            chk("t1_en", 32'(imem_en), 1);
            chk("t1_fvalid", 32'(fetch_valid), (k >= 2) ? 1 : 0);
            if (k >= 2) begin
                chk("t1_ftid", 32'(fetch_tid), 32'((k - 2) % 16));
                chk("t1_fpc", 32'(fetch_pc), 32'(4 * ((k - 2) / 16)));
            end
        end

        // 2: redirect tid 5 to 0x123 while slot 2 is current
        do_reset();
        ticks(2);
        redirect(4'd5, 12'h123);
        ticks(2);
        chk("t2_slot3_pc", 32'(fetch_pc), 0);
        tick();
        chk("t2_addr", 32'(imem_addr), 32'h048);
        chk("t2_en", 32'(imem_en), 1);
        tick();
        chk("t2_fvalid", 32'(fetch_valid), 1);
        chk("t2_ftid", 32'(fetch_tid), 5);
        chk("t2_fpc", 32'(fetch_pc), 32'h120);
        tick();
        chk("t2_next_tid", 32'(fetch_tid), 6);
        chk("t2_next_pc", 32'(fetch_pc), 0);

        // 3: redirect tid 7 while slot 7 is current -> bubble, then 0x040, 0x044
        do_reset();
        ticks(7);
        redirect(4'd7, 12'h040);
        chk("t3_bubble_en", 32'(imem_en), 0);
        tick();
        chk("t3_bubble_valid", 32'(fetch_valid), 0);
        chk("t3_bubble_tid", 32'(fetch_tid), 7);
        ticks(16);
        chk("t3_v1_valid", 32'(fetch_valid), 1);
        chk("t3_v1_tid", 32'(fetch_tid), 7);
        chk("t3_v1_pc", 32'(fetch_pc), 32'h040);
        ticks(16);
        chk("t3_v2_tid", 32'(fetch_tid), 7);
        chk("t3_v2_pc", 32'(fetch_pc), 32'h044);

        // 4: upper half disabled for two rounds, then re-enabled
        do_reset();
        for (int k = 1; k <= 48; k++) begin
            thread_en = (k <= 32) ? 16'h00FF : 16'hFFFF;
            tick();
            if (k >= 2) begin
                chk("t4_ftid", 32'(fetch_tid), 32'((k - 2) % 16));
                chk("t4_fvalid", 32'(fetch_valid),
                    ((((k - 2) % 16) < 8) || (k - 1 >= 33)) ? 1 : 0);
                chk("t4_fpc", 32'(fetch_pc),
                    (((k - 2) % 16) < 8) ? 32'(4 * ((k - 2) / 16)) : 0);
            end
        end

        // 5: PC wrap on tid 3; redirect to 3 while slot 0 issues
        do_reset();
        redirect(4'd3, 12'hFFE);
        chk("t5_slot0_en", 32'(imem_en), 1);
        tick();
        chk("t5_slot0_valid", 32'(fetch_valid), 1);
        ticks(2);
        chk("t5_addr1", 32'(imem_addr), 32'h3FF);
        tick();
        chk("t5_fpc1", 32'(fetch_pc), 32'hFFC);
        chk("t5_ftid1", 32'(fetch_tid), 3);
        ticks(12);
        chk("t5_slot0_addr2", 32'(imem_addr), 1);
        ticks(3);
        chk("t5_addr2", 32'(imem_addr), 0);
        tick();
        chk("t5_fpc2", 32'(fetch_pc), 0);
        chk("t5_ftid2", 32'(fetch_tid), 3);

        // 6: mid-run reset, then run_en low for 5 cycles
        do_reset();
        ticks(20);
        reset_n = 1'b0;
        tick();
        chk("t6_rst_en", 32'(imem_en), 0);
        chk("t6_rst_valid", 32'(fetch_valid), 0);
        reset_n = 1'b1;
        tick();
        chk("t6_addr", 32'(imem_addr), 0);
        chk("t6_en", 32'(imem_en), 1);
        chk("t6_valid0", 32'(fetch_valid), 0);
        tick();
        chk("t6_valid1", 32'(fetch_valid), 1);
        chk("t6_tid", 32'(fetch_tid), 0);
        chk("t6_pc", 32'(fetch_pc), 0);
        run_en = 1'b0;
        for (int a = 1; a <= 5; a++) begin
            tick();
            chk("t6_hold_en", 32'(imem_en), 0);
            chk("t6_drain_valid", 32'(fetch_valid), (a == 1) ? 1 : 0);
            if (a >= 3) chk("t6_hold_tid", 32'(fetch_tid), 2);
        end
        run_en = 1'b1;
        tick();
        chk("t6_resume_en", 32'(imem_en), 1);
        chk("t6_resume_addr", 32'(imem_addr), 0);
        tick();
        chk("t6_resume_valid", 32'(fetch_valid), 1);
        chk("t6_resume_tid", 32'(fetch_tid), 2);
        chk("t6_resume_pc", 32'(fetch_pc), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/barrel_fetch_unit.md
Name: barrel_fetch_unit

Overview:
Fetch stage of the 16-thread barrel RISC-V core. Rotates a thread slot every cycle, holds one PC per hardware thread, and drives the instruction BRAM read address. Emits thread id and PC aligned with the 1-cycle BRAM read data. Accepts PC redirects for taken branches and jumps from the execute stage and feeds decode.

Parameters:
NUM_THREADS, 16, number of hardware threads (power of two, ≥2)
ADDR_WIDTH, 10, instruction BRAM word-address width
PC_WIDTH, ADDR_WIDTH+2, byte-address PC width (12)
STARTUP_ADDR, 12'h000, reset PC for every thread (byte address)

Ports:
clk  in  1  core clock
reset_n  in  1  reset: synchronous, active-low
run_en  in  1  global run; low freezes slot rotation and issues bubbles
thread_en  in  NUM_THREADS  per-thread enable mask; bit t low = slot t issues a bubble
redirect_valid  in  1  execute-stage PC redirect strobe
redirect_tid  in  clog2(NUM_THREADS)  thread being redirected
redirect_pc  in  PC_WIDTH  new byte PC; bits [1:0] ignored and forced to 0
imem_addr  out  ADDR_WIDTH  BRAM word address (registered)
imem_en  out  1  BRAM read enable (registered)
fetch_valid  out  1  instruction on BRAM dout belongs to a live slot
fetch_tid  out  clog2(NUM_THREADS)  thread id of that instruction
fetch_pc  out  PC_WIDTH  byte PC of that instruction

Behaviour:
- All state is updated on the rising clk edge. Reset is sampled only at the edge when reset_n=0.
- Reset values:
  - slot counter = 0
  - every pc[t] = STARTUP_ADDR with bits [1:0] cleared
  - imem_addr = 0, imem_en = 0
  - fetch_valid = 0, fetch_tid = 0, fetch_pc = 0
- S0 (slot select):
  - tid_q is the current slot.
  - issue = run_en & thread_en[tid_q] & ~(redirect_valid & redirect_tid==tid_q).
  - tid_q increments mod NUM_THREADS only when run_en=1. Wrap goes 15→0.
- S1 (BRAM address), registered from S0:
  - imem_addr <= pc[tid_q][PC_WIDTH-1:2]
  - imem_en <= issue
  - s1_tid <= tid_q, s1_pc <= pc[tid_q], s1_valid <= issue
- S2 (output), registered from S1:
  - fetch_valid <= s1_valid, fetch_tid <= s1_tid, fetch_pc <= s1_pc
- Latency: a slot selected in cycle N drives imem_addr in N+1. Its instruction, fetch_valid, fetch_tid and fetch_pc are all valid in N+2.
- PC update, one write port per cycle, priority highest first:
  1. redirect_valid: pc[redirect_tid] <= {redirect_pc[PC_WIDTH-1:2], 2'b00}
  2. issue: pc[tid_q] <= pc[tid_q] + 4
- Boundary and simultaneous-event rules:
  - Redirect and issue on different threads in the same cycle: both updates are applied.
  - Redirect to the current slot thread: the redirect wins. That slot issues a bubble (fetch_valid=0 two cycles later) and its PC is not incremented. The new PC is fetched on the next visit to that slot.
  - PC increment wraps modulo 2^PC_WIDTH: 12'hFFC + 4 → 12'h000. No flag is raised.
  - thread_en[t]=0: slot t still consumes its cycle, issues a bubble, and pc[t] holds. Redirects to a disabled thread are still written.
  - run_en=0: tid_q holds, no issue, pc array frozen except for redirects. The pipeline drains, so fetch_valid goes 0 within 2 cycles.
  - Reset mid-operation: at the reset edge, S1 and S2 valids clear and all PCs reload. Instructions already in flight are discarded, not completed.
- The PC array (NUM_THREADS×PC_WIDTH) is registers or LUTRAM with combinational read. No BRAM read latency inside this block.

Decomposition:
- Shared package, riscv_pkg, gains:
  - PC_WIDTH = ADDR_WIDTH+2
  - TID_WIDTH = clog2(NUM_THREADS)
  - typedef logic [TID_WIDTH-1:0] tid_t
  - typedef logic [PC_WIDTH-1:0] pc_t
  - typedef struct {valid, tid, pc} fetch_bundle_t
- The block reuses STARTUP_ADDR, ADDR_WIDTH and NUM_THREADS from that package.
- One sub-module: thread_slot_counter (modulo counter with enable, synchronous active-low reset).

Test Plan:
1. Reset, then run_en=1 with all threads enabled for 40 cycles → imem_addr 0 for cycles 1..16 (tids 0..15), then 1 for cycles 17..32. fetch_tid sequence 0..15 repeats, lagging the slot by 2 cycles. fetch_pc steps 0x000 then 0x004 per thread.
2. Redirect tid 5 to 0x123 while slot=2 → on slot 5's next visit imem_addr=0x048 and fetch_pc=0x120 two cycles later. Other threads are unaffected.
3. Redirect tid 7 to 0x040 in the same cycle slot=7 → fetch_valid=0 for that slot two cycles later. The next visit of tid 7 fetches pc 0x040, then 0x044.
4. thread_en=16'h00FF → slots 8..15 give fetch_valid=0 and pc[8..15] stay 0. Re-enabling gives their first fetch_pc=0x000.
5. Force pc[3]=0xFFC by redirect, then issue tid 3 twice → fetch_pc 0xFFC then 0x000 (wrap). imem_addr 0x3FF then 0x000.
6. Assert reset_n=0 for 1 cycle mid-run → at the next edge fetch_valid=0, imem_en=0, tid restarts at 0, and all PCs return to STARTUP_ADDR. run_en low for 5 cycles holds the slot and gives fetch_valid=0 after 2 cycles.
